lcd_bus_responder: RTL
======================

# lcd_bus_responder

Synthesizable HD44780-style responder for the parallel LCD bus, acting as the display end of the character-LCD interface.
- Decodes the command and data writes issued by the LCD controller.
- Holds a 2×16 DDRAM image, cursor address and busy flag, and answers busy-flag and data reads.
- Sits in loopback builds and test benches in place of the physical panel.
- The CPU or bench inspects the displayed text through a side read port.

## Interface
- CMD_BUSY_CYCLES, 2000: busy duration after ordinary commands and data writes (40 µs at 50 MHz).
- CLEAR_BUSY_CYCLES, 76000: busy duration after Clear and Return Home (1.52 ms at 50 MHz).
- clk  in  1  system clock. One clock domain.
- reset  in  1  reset, synchronous, active-high.
- lcd_data_in  in  8  bus data from the controller.
- lcd_rs  in  1  0 = command/status, 1 = data.
- lcd_rw  in  1  0 = write, 1 = read.
- lcd_en  in  1  enable strobe; transaction commits on its falling edge.
- lcd_data_out  out  8  read data driven back to the bus.
- lcd_data_oe  out  1  high while a read is being served (lcd_en=1, lcd_rw=1).
- rd_addr  in  5  side-port index: 0–15 = line 1 columns, 16–31 = line 2 columns.
- rd_char  out  8  DDRAM byte at rd_addr, registered (1-cycle latency).
- cursor_addr  out  7  current DDRAM address counter (AC).
- busy  out  1  busy flag.
- display_on  out  1  D bit from Display Control.
- func_8bit  out  1  DL bit from Function Set.
- func_2line  out  1  N bit from Function Set.
- entry_inc  out  1  I/D bit from Entry Mode.
- wr_strobe  out  1  1-cycle pulse on each accepted data write.
- cmd_strobe  out  1  1-cycle pulse on each accepted command.
- protocol_err  out  1  1-cycle pulse when a write arrives while busy.

## Operation
- Reset values:
  - DDRAM all 0x20.
  - cursor_addr 0, busy 0, display_on 0, func_8bit 1, func_2line 0, entry_inc 1.
  - All strobes 0, lcd_data_out 0, lcd_data_oe 0, rd_char 0x20.
  - Busy counter 0.
- Reset mid-busy aborts the busy period immediately.
- Inputs rs/rw/data/en are registered every cycle (rs_q, rw_q, data_q, en_q).
- A transaction event occurs when en_q=1 and lcd_en=0. It uses rs_q/rw_q/data_q.
- States:
  - IDLE: busy=0.
  - BUSY: counter running, busy=1.
  - BUSY→IDLE when the counter reaches 0.
- Write while busy (rw_q=0, state BUSY): ignored. protocol_err pulses. Counter is not restarted.
- Command decode (rs_q=0, rw_q=0), priority by the highest set bit:
  - 1xxxxxxx: AC = data_q[6:0].
  - 01xxxxxx: CGRAM address. Accepted, no effect.
  - 001xxxxx: func_8bit = d[4], func_2line = d[3].
  - 0001xxxx: if d[3]=0, AC moves +1 (d[2]=1) or −1 (d[2]=0) using the wrap rule. Display shift (d[3]=1) is ignored.
  - 00001xxx: display_on = d[2].
  - 000001xx: entry_inc = d[1].
  - 0000001x: AC = 0. Uses CLEAR busy.
  - 00000001: all DDRAM = 0x20 in the same cycle, AC = 0, entry_inc = 1. Uses CLEAR busy.
  - 0x00: accepted, no effect, CMD busy.
- Data write (rs_q=1, rw_q=0):
  - If AC is in 0x00–0x0F or 0x40–0x4F, store at index {AC[6], AC[3:0]}. Otherwise discard.
  - In either case advance AC by entry_inc, then start CMD busy.
- AC wrap rule:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
  - Values 0x28–0x3F and 0x68–0x7F are legal only via a Set-Address command; incrementing from one of them simply adds 1 (7-bit).
- Reads (rw=1) are allowed in any state and never error.
  - While lcd_en=1 and lcd_rw=1: lcd_data_oe=1.
  - lcd_data_out = {busy, cursor_addr} when rs=0.
  - lcd_data_out = DDRAM[AC] when rs=1, or 0x20 if AC is out of range.
  - The data-read falling edge advances AC. It does not set busy.

## Timing
- An event detected at edge E commits all state, strobes and busy=1 at edge E.
- Busy lasts exactly N cycles after E (busy low at edge E+N).
- Status read outputs are registered: lcd_data_out/oe follow lcd_en/rw/rs with 1-cycle latency and drop 1 cycle after lcd_en falls.
- rd_char reflects a write one cycle after commit.
- An event and a busy expiry on the same edge: the expiry is processed first, so the write is accepted.

## Test plan
- Reset check: assert reset 2 cycles. Required: every output at its reset value; rd_char=0x20 for all rd_addr 0–31.
- Init + text (CMD=4, CLEAR=8):
  - Stimulus: writes 0x38, 0x0C, 0x01, 0x06 spaced 12 cycles, then data 'L', 'O'.
  - Required: func_2line=1, display_on=1, rd_addr0=0x4C, rd_addr1=0x4F, cursor_addr=0x02.
- Line 2: command 0xC0, then '+'. Required: rd_addr16=0x2B, cursor_addr=0x41.
- Wrap:
  - Set 0xA7, write 'A'. Required: nothing stored, cursor_addr=0x40.
  - Set 0xCF, write 'Z'. Required: rd_addr31=0x5A, cursor_addr=0x50.
- Busy violation: command 0x01, then data 'X' committed 2 cycles later. Required: protocol_err pulse, DDRAM all 0x20, busy drops exactly 8 cycles after the clear.
- Status read:
  - Stimulus: command 0xC5, then rs=0, rw=1, en=1 during busy.
  - Required: lcd_data_out=0xC5, oe=1. After busy expires, the same read returns 0x45.
  - Reset asserted mid-busy: busy=0 on the next edge.

Source files
------------

// File: rtl/lcd_bus_responder.sv
// Display end of an HD44780-style parallel LCD bus: decodes controller writes, keeps a
// 2x16 DDRAM image, serves status/data reads and exposes the text on a side port.
module lcd_bus_responder #(
  parameter int CMD_BUSY_CYCLES   = 2000,
  parameter int CLEAR_BUSY_CYCLES = 76000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lcd_data_in,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cursor_addr,
  output logic       busy,
  output logic       display_on,
  output logic       func_8bit,
  output logic       func_2line,
  output logic       entry_inc,
  output logic       wr_strobe,
  output logic       cmd_strobe,
  output logic       protocol_err
);
  localparam int MAX_BUSY = (CMD_BUSY_CYCLES > CLEAR_BUSY_CYCLES) ? CMD_BUSY_CYCLES : CLEAR_BUSY_CYCLES;
  localparam int CW = $clog2(MAX_BUSY + 1);
  localparam logic [CW-1:0] CMD_LOAD   = CW'(CMD_BUSY_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_BUSY_CYCLES - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  logic       rs_q, rw_q, en_q;
  logic [7:0] data_q;
  logic [7:0] ddram [32];

  logic       txn, wr_txn, busy_hold, accept, clear_cmd, ac_valid;
  logic [4:0] ac_index;
  logic [7:0] ac_byte;

  // Address counter step with the two-line wrap points of a 2x16 panel.
  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic up);
    logic [6:0] r;
    if (up) begin
      if (ac == 7'h27)      r = 7'h40;
      else if (ac == 7'h67) r = 7'h00;
      else                  r = ac + 7'd1;
    end else begin
      if (ac == 7'h00)      r = 7'h67;
      else if (ac == 7'h40) r = 7'h27;
      else                  r = ac - 7'd1;
    end
    return r;
  endfunction

  assign txn       = en_q & ~lcd_en;
  // A busy period ending on this edge no longer blocks a write arriving on it.
  assign busy_hold = (state == ST_BUSY) && (cnt != '0);
  assign wr_txn    = txn & ~rw_q;
  assign accept    = wr_txn & ~busy_hold;
  assign clear_cmd = ~rs_q && (data_q[7:2] == 6'd0) && (data_q[1:0] != 2'd0);
  assign ac_valid  = (cursor_addr[5:4] == 2'b00);
  assign ac_index  = {cursor_addr[6], cursor_addr[3:0]};
  assign ac_byte   = ac_valid ? ddram[ac_index] : 8'h20;
  assign busy      = (state == ST_BUSY);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (state == ST_BUSY) begin
      if (cnt == '0) state_next = ST_IDLE;
      else           cnt_next   = cnt - 1'b1;
    end
    if (accept) begin
      state_next = ST_BUSY;
      cnt_next   = clear_cmd ? CLEAR_LOAD : CMD_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q         <= 1'b0;
      rw_q         <= 1'b0;
      en_q         <= 1'b0;
      data_q       <= 8'h00;
      cursor_addr  <= 7'h00;
      display_on   <= 1'b0;
      func_8bit    <= 1'b1;
      func_2line   <= 1'b0;
      entry_inc    <= 1'b1;
      wr_strobe    <= 1'b0;
      cmd_strobe   <= 1'b0;
      protocol_err <= 1'b0;
      lcd_data_out <= 8'h00;
      lcd_data_oe  <= 1'b0;
      rd_char      <= 8'h20;
      for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
    end else begin
      rs_q         <= lcd_rs;
      rw_q         <= lcd_rw;
      en_q         <= lcd_en;
      data_q       <= lcd_data_in;
      wr_strobe    <= 1'b0;
      cmd_strobe   <= 1'b0;
      protocol_err <= wr_txn & busy_hold;
      rd_char      <= ddram[rd_addr];
      lcd_data_oe  <= lcd_en & lcd_rw;
      if (lcd_en && lcd_rw) lcd_data_out <= lcd_rs ? ac_byte : {busy, cursor_addr};
      else                  lcd_data_out <= 8'h00;

      if (txn && rw_q && rs_q) cursor_addr <= ac_step(cursor_addr, entry_inc);

      if (accept && rs_q) begin
        wr_strobe <= 1'b1;
        if (ac_valid) ddram[ac_index] <= data_q;
        cursor_addr <= ac_step(cursor_addr, entry_inc);
      end

      if (accept && !rs_q) begin
        cmd_strobe <= 1'b1;
        casez (data_q)
          8'b1???????: cursor_addr <= data_q[6:0];
          8'b01??????: begin end
          8'b001?????: begin
            func_8bit  <= data_q[4];
            func_2line <= data_q[3];
          end
          8'b0001????: if (!data_q[3]) cursor_addr <= ac_step(cursor_addr, data_q[2]);
          8'b00001???: display_on <= data_q[2];
          8'b000001??: entry_inc <= data_q[1];
          8'b0000001?: cursor_addr <= 7'h00;
          8'b00000001: begin
            for (int i = 0; i < 32; i++) ddram[i] <= 8'h20;
            cursor_addr <= 7'h00;
            entry_inc   <= 1'b1;
          end
          default: begin end
        endcase
      end
    end
  end
endmodule
